// File: rtl/fpu_sequencer_pkg.sv
// Shared definitions for the FP instruction sequencer: op codes, the fixed
// arithmetic-core latency table and the sequencer state encoding.
package fpu_sequencer_pkg;

    localparam logic [3:0] OP_FEQ     = 4'd0;
    localparam logic [3:0] OP_FLT     = 4'd1;
    localparam logic [3:0] OP_FLE     = 4'd2;
    localparam logic [3:0] OP_FLEABS  = 4'd3;
    localparam logic [3:0] OP_FHALF   = 4'd4;
    localparam logic [3:0] OP_FSIGNJ  = 4'd5;
    localparam logic [3:0] OP_FSIGNJN = 4'd6;
    localparam logic [3:0] OP_FSIGNJX = 4'd7;
    localparam logic [3:0] OP_FADD    = 4'd8;
    localparam logic [3:0] OP_FSUB    = 4'd9;
    localparam logic [3:0] OP_FDIV    = 4'd10;
    localparam logic [3:0] OP_FSQRT   = 4'd11;
    localparam logic [3:0] OP_FCVTWS  = 4'd12;
    localparam logic [3:0] OP_FCVTSW  = 4'd13;
    localparam logic [3:0] OP_FMUL    = 4'd14;
    localparam logic [3:0] OP_FONE    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Cycles from core_start to the cycle in which core_result is captured.
    function automatic logic [3:0] op_latency(input logic [3:0] op);
        logic [3:0] lat;
        case (op)
            OP_FADD, OP_FSUB:              lat = 4'd3;
            OP_FDIV, OP_FSQRT:             lat = 4'd10;
            OP_FMUL, OP_FCVTWS, OP_FCVTSW: lat = 4'd2;
            default:                       lat = 4'd1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Bundle of the upstream instruction port, the external core port and the
// result port. master = instruction/core side, slave = the sequencer.
// Handshake: in_valid presents one instruction; while stall=1 upstream holds
// it stable; out_valid is a single-cycle pulse with out_data/out_rd/out_int_dst.
interface fpu_sequencer_if;
    import fpu_sequencer_pkg::*;

    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        in_int_dst;
    logic        flush;
    logic        stall;
    logic        core_start;
    logic [2:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_result;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_int_dst;
    logic        busy;
    state_t      dbg_state;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, in_int_dst, flush, core_result,
        input  stall, core_start, core_op, core_a, core_b,
        input  out_valid, out_data, out_rd, out_int_dst, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, in_int_dst, flush, core_result,
        output stall, core_start, core_op, core_a, core_b,
        output out_valid, out_data, out_rd, out_int_dst, busy, dbg_state
    );

endinterface

// File: rtl/fpu_sequencer_simple.sv
// Single-cycle FP ops that need no arithmetic core: sign injection, halving
// and sign-magnitude compares (NaN inputs are not supported).
module fpu_simple_unit
    import fpu_sequencer_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic       w_both_zero;
    logic       w_eq;
    logic       w_lt;
    logic [7:0] w_exp_dec;

    always_comb begin
        w_both_zero = (i_a[30:0] == 31'd0) && (i_b[30:0] == 31'd0);
        w_eq        = w_both_zero || (i_a == i_b);
        // Opposite signs order by sign alone; equal negative signs reverse the magnitude order.
        if (w_both_zero)            w_lt = 1'b0;
        else if (i_a[31] != i_b[31]) w_lt = i_a[31];
        else if (i_a[31])           w_lt = i_b[30:0] < i_a[30:0];
        else                        w_lt = i_a[30:0] < i_b[30:0];
        w_exp_dec = i_a[30:23] - 8'd1;

        o_result = '0;
        case ({1'b0, i_op})
            OP_FEQ:     o_result[0] = w_eq;
            OP_FLT:     o_result[0] = w_lt;
            OP_FLE:     o_result[0] = w_lt || w_eq;
            OP_FLEABS:  o_result[0] = i_a[30:0] <= i_b[30:0];
            OP_FHALF:   o_result = (i_a[30:23] == 8'd0) ? {i_a[31], 31'd0}
                                                        : {i_a[31], w_exp_dec, i_a[22:0]};
            OP_FSIGNJ:  o_result = {i_b[31], i_a[30:0]};
            OP_FSIGNJN: o_result = {~i_b[31], i_a[30:0]};
            OP_FSIGNJX: o_result = {i_a[31] ^ i_b[31], i_a[30:0]};
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Sequences decoded FP instructions: simple ops retire in one cycle, multi-cycle
// ops are launched on the external core and their result captured at a fixed latency.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
(
    input logic           clk,
    input logic           rst,
    fpu_sequencer_if.slave bus
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_simple_v;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_rd;
    logic        r_out_int_dst;
    logic        w_launch;
    logic        w_simple;
    logic        w_capture;
    logic        w_stall;
    logic        w_done_v;
    logic [31:0] w_simple_res;

    fpu_simple_unit u_simple (
        .i_op     (bus.in_op[2:0]),
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .o_result (w_simple_res)
    );

    // rst gates acceptance so combinational launch outputs read zero while in reset.
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_simple  = 1'b0;
        w_capture = 1'b0;
        w_stall   = 1'b0;
        w_done_v  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst && bus.in_valid && !bus.flush) begin
                    if (bus.in_op[3]) begin
                        w_launch = 1'b1;
                        w_stall  = 1'b1;
                        w_next   = ST_BUSY;
                    end else begin
                        w_simple = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == 4'd0) begin
                        w_capture = 1'b1;
                        w_next    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_done_v = !bus.flush;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_simple_v    <= 1'b0;
            r_out_data    <= '0;
            r_out_rd      <= '0;
            r_out_int_dst <= 1'b0;
        end else begin
            r_simple_v <= w_simple;
            if (w_launch) begin
                r_cnt         <= op_latency(bus.in_op) - 4'd1;
                r_op          <= bus.in_op[2:0];
                r_a           <= bus.in_a;
                r_b           <= bus.in_b;
                r_out_rd      <= bus.in_rd;
                r_out_int_dst <= bus.in_int_dst;
            end else if (r_state == ST_BUSY && !bus.flush && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_simple) begin
                r_out_data    <= w_simple_res;
                r_out_rd      <= bus.in_rd;
                r_out_int_dst <= bus.in_int_dst;
            end
            if (w_capture) r_out_data <= bus.core_result;
        end
    end

    // Operands are shown straight from the input in the launch cycle, then from the latches.
    assign bus.stall       = w_stall;
    assign bus.core_start  = w_launch;
    assign bus.core_op     = w_launch ? bus.in_op[2:0] : r_op;
    assign bus.core_a      = w_launch ? bus.in_a : r_a;
    assign bus.core_b      = w_launch ? bus.in_b : r_b;
    assign bus.out_valid   = r_simple_v || w_done_v;
    assign bus.out_data    = r_out_data;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_int_dst = r_out_int_dst;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: directed scenarios plus randomized instruction
// streams checked against a behavioural model and an expected-result queue.
module tb_fpu_sequencer;
    import fpu_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic check_en;
    int   stall_cnt;
    int   start_cnt;

    // {cycle[31:0], rd[4:0], int_dst, data[31:0]}
    logic [69:0] exp_q[$];
    logic [69:0] e;
    logic [31:0] last_data;
    logic        last_int_dst;

    fpu_sequencer_if bus ();

    fpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd8, 4'd9:          return 3;
            4'd10, 4'd11:        return 10;
            4'd12, 4'd13, 4'd14: return 2;
            default:             return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_simple(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint ka, kb;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        case (op)
            4'd0: return (ka == kb) ? 32'd1 : 32'd0;
            4'd1: return (ka < kb) ? 32'd1 : 32'd0;
            4'd2: return (ka <= kb) ? 32'd1 : 32'd0;
            4'd3: return (longint'(a[30:0]) <= longint'(b[30:0])) ? 32'd1 : 32'd0;
            4'd4: return (a[30:23] == 8'd0) ? (a & 32'h8000_0000) : (a - 32'h0080_0000);
            4'd5: return (a & 32'h7FFF_FFFF) | (b & 32'h8000_0000);
            4'd6: return (a & 32'h7FFF_FFFF) | (~b & 32'h8000_0000);
            4'd7: return a ^ (b & 32'h8000_0000);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = other;
            3:       v = other ^ 32'h8000_0000;
            default: v = $urandom;
        endcase
        if (v[30:23] == 8'hFF) v[30] = 1'b0;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (check_en && !rst) begin
            if (exp_q.size() != 0 && int'(exp_q[0][69:38]) == cyc) begin
                e = exp_q.pop_front();
                check32("out_valid", 32'(bus.out_valid), 32'd1);
                check32("out_data", bus.out_data, e[31:0]);
                check32("out_rd", 32'(bus.out_rd), 32'(e[37:33]));
                check32("out_int_dst", 32'(bus.out_int_dst), 32'(e[32]));
            end else begin
                check32("out_valid_quiet", 32'(bus.out_valid), 32'd0);
            end
            if (bus.out_valid) begin
                last_data    = bus.out_data;
                last_int_dst = bus.out_int_dst;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.stall) stall_cnt++;
            if (bus.core_start) start_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycle();
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.core_result = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic do_simple(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic intd);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        bus.in_rd = rd; bus.in_int_dst = intd; bus.flush = 1'b0;
        exp_q.push_back({32'(cyc + 1), rd, intd, model_simple(op, a, b)});
        @(negedge clk);
        check32("simple_stall", 32'(bus.stall), 32'd0);
        check32("simple_core_start", 32'(bus.core_start), 32'd0);
        check32("simple_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // flush_at: -1 for none, else cycle index after launch (1..LAT+1) carrying flush.
    task automatic do_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic intd, input int flush_at,
                            input logic [31:0] res);
        int lat;
        logic exp_stall;
        lat = lat_of(op);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        bus.in_rd = rd; bus.in_int_dst = intd; bus.flush = 1'b0;
        bus.core_result = $urandom;
        if (flush_at < 0) exp_q.push_back({32'(cyc + lat + 1), rd, intd, res});
        @(negedge clk);
        check32("launch_core_start", 32'(bus.core_start), 32'd1);
        check32("launch_stall", 32'(bus.stall), 32'd1);
        check32("launch_core_op", 32'(bus.core_op), 32'(op[2:0]));
        check32("launch_core_a", bus.core_a, a);
        check32("launch_core_b", bus.core_b, b);
        for (int i = 1; i <= lat + 1; i++) begin
            @(posedge clk); #1;
            bus.core_result = (i == lat) ? res : 32'($urandom);
            bus.flush = (i == flush_at);
            @(negedge clk);
            exp_stall = (i <= lat) && (i != flush_at);
            check32("run_stall", 32'(bus.stall), 32'(exp_stall));
            check32("run_core_start", 32'(bus.core_start), 32'd0);
            check32("run_busy", 32'(bus.busy), 32'd1);
            if (i <= lat) begin
                check32("run_core_a", bus.core_a, a);
                check32("run_core_b", bus.core_b, b);
                check32("run_core_op", 32'(bus.core_op), 32'(op[2:0]));
            end
            if (i == flush_at) break;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic do_flush_idle(input logic [3:0] op);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = $urandom; bus.in_b = $urandom;
        bus.in_rd = 5'($urandom); bus.in_int_dst = 1'($urandom); bus.flush = 1'b1;
        @(negedge clk);
        check32("idle_flush_core_start", 32'(bus.core_start), 32'd0);
        check32("idle_flush_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic check_last(input string name, input logic [31:0] exp_data,
                              input logic exp_intd);
        @(negedge clk); #1;
        check32(name, last_data, exp_data);
        check32({name, "_int_dst"}, 32'(last_int_dst), 32'(exp_intd));
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string name);
        check32({name, "_stall"}, 32'(bus.stall), 32'd0);
        check32({name, "_core_start"}, 32'(bus.core_start), 32'd0);
        check32({name, "_core_a"}, bus.core_a, 32'd0);
        check32({name, "_core_b"}, bus.core_b, 32'd0);
        check32({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check32({name, "_out_data"}, bus.out_data, 32'd0);
        check32({name, "_out_rd"}, 32'(bus.out_rd), 32'd0);
        check32({name, "_out_int_dst"}, 32'(bus.out_int_dst), 32'd0);
        check32({name, "_busy"}, 32'(bus.busy), 32'd0);
        check32({name, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, t0, lat, flush_at;
        logic [3:0]  op;
        logic [31:0] a, b;

        checks = 0; errors = 0; check_en = 1'b0;
        stall_cnt = 0; start_cnt = 0;
        last_data = '0; last_int_dst = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = OP_FDIV; bus.in_a = 32'h1234_5678;
        bus.in_b = 32'h9ABC_DEF0; bus.in_rd = 5'd1; bus.in_int_dst = 1'b1;
        bus.flush = 1'b0; bus.core_result = 32'hDEAD_BEEF;

        // Model pins.
        check32("pin_fsignjn", model_simple(OP_FSIGNJN, 32'h3F80_0000, 32'h3F80_0000), 32'hBF80_0000);
        check32("pin_fle", model_simple(OP_FLE, 32'h8000_0000, 32'h0), 32'd1);
        check32("pin_flt", model_simple(OP_FLT, 32'h8000_0000, 32'h0), 32'd0);
        check32("pin_fhalf", model_simple(OP_FHALF, 32'h4000_0000, 32'h0), 32'h3F80_0000);
        check32("pin_flt_neg", model_simple(OP_FLT, 32'hC000_0000, 32'hBF80_0000), 32'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        check_en = 1'b1;
        idle_cycle();

        // FSIGNJN single-cycle path.
        s0 = stall_cnt;
        do_simple(OP_FSIGNJN, 32'h3F80_0000, 32'h3F80_0000, 5'd3, 1'b0);
        check_last("fsignjn", 32'hBF80_0000, 1'b0);
        check32("fsignjn_no_stall", 32'(stall_cnt - s0), 32'd0);

        // FDIV with fixed core result.
        s0 = stall_cnt; t0 = start_cnt;
        do_multi(OP_FDIV, 32'h4040_0000, 32'h3F80_0000, 5'd7, 1'b0, -1, 32'h4040_0000);
        check32("fdiv_stall_cycles", 32'(stall_cnt - s0), 32'd11);
        check32("fdiv_start_pulses", 32'(start_cnt - t0), 32'd1);
        check_last("fdiv_data", 32'h4040_0000, 1'b0);

        // Signed-zero compares.
        do_simple(OP_FLE, 32'h8000_0000, 32'h0000_0000, 5'd9, 1'b1);
        check_last("fle_zero", 32'd1, 1'b1);
        do_simple(OP_FLT, 32'h8000_0000, 32'h0000_0000, 5'd10, 1'b0);
        check_last("flt_zero", 32'd0, 1'b0);

        // FHALF normal and zero-exponent.
        do_simple(OP_FHALF, 32'h4000_0000, 32'h0, 5'd11, 1'b0);
        check_last("fhalf_two", 32'h3F80_0000, 1'b0);
        do_simple(OP_FHALF, 32'h8000_0001, 32'h0, 5'd12, 1'b0);
        check_last("fhalf_denorm", 32'h8000_0000, 1'b0);

        // FMUL flushed in its second BUSY cycle, then a normal FADD.
        do_multi(OP_FMUL, 32'h4000_0000, 32'h4000_0000, 5'd13, 1'b0, 2, 32'h4080_0000);
        idle_cycle();
        do_multi(OP_FADD, 32'h3F80_0000, 32'h3F80_0000, 5'd14, 1'b0, -1, 32'h4000_0000);
        check_last("fadd_after_flush", 32'h4000_0000, 1'b0);

        // Flush in IDLE and in DONE.
        do_flush_idle(OP_FSQRT);
        do_flush_idle(OP_FEQ);
        idle_cycle();
        do_multi(OP_FONE, 32'h1, 32'h2, 5'd15, 1'b1, 2, 32'h5555_AAAA);

        // Reset during FSQRT BUSY.
        bus.in_valid = 1'b1; bus.in_op = OP_FSQRT; bus.in_a = 32'h4080_0000;
        bus.in_b = 32'h0; bus.in_rd = 5'd20; bus.in_int_dst = 1'b1; bus.flush = 1'b0;
        @(negedge clk);
        check32("fsqrt_start", 32'(bus.core_start), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            bus.core_result = $urandom;
        end
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        check_all_zero("mid_reset_hold");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (10) idle_cycle();
        do_simple(OP_FEQ, 32'h0000_0000, 32'h8000_0000, 5'd21, 1'b1);
        check_last("feq_after_reset", 32'd1, 1'b1);

        // Randomized stream.
        for (int n = 0; n < 250; n++) begin
            op = 4'($urandom_range(0, 15));
            b  = rand_fp($urandom);
            a  = rand_fp(b);
            if (op[3]) begin
                lat = lat_of(op);
                flush_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, lat + 1)) : -1;
                do_multi(op, a, b, 5'($urandom), 1'($urandom), flush_at, $urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                do_flush_idle(op);
            end else begin
                do_simple(op, a, b, 5'($urandom), 1'($urandom));
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (3) idle_cycle();
        check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  decoded FP instruction present; held stable by upstream while stall=1.
REQ-004 in_op  in  4  decoded FP ALU control code; bit3=1 means multi-cycle op.
REQ-005 in_a, in_b  in  32 each  IEEE-754 single operands.
REQ-006 in_rd  in  5  destination register tag.
REQ-007 in_int_dst  in  1  result targets integer file (compare, fcvt.w.s).
REQ-008 flush  in  1  kill in-flight op.
REQ-009 stall  out  1  freeze upstream pipeline.
REQ-010 core_start  out  1  one-cycle launch pulse to the external arithmetic core.
REQ-011 core_op  out  3  in_op[2:0] of the launched op.
REQ-012 core_a, core_b  out  32 each  latched operands, stable from the launch cycle to completion.
REQ-013 core_result  in  32  core output, valid at the op's fixed latency.
REQ-014 out_valid  out  1  registered one-cycle result pulse.
REQ-015 out_data  out  32  result; out_rd 5 and out_int_dst 1 accompany it.
REQ-016 busy  out  1  state != IDLE.

Function
REQ-017 States: IDLE, BUSY, DONE.
REQ-018 IDLE, in_valid, in_op[3]=0: stall=0; result computed combinationally; out_valid=1 with registered data next cycle; stay IDLE.
REQ-019 IDLE, in_valid, in_op[3]=1: stall=1 that cycle; core_start=1; latch operands, rd, int_dst; cnt<=LAT(op)-1; go BUSY.
REQ-020 BUSY: stall=1; cnt decrements each cycle; at cnt=0, capture core_result into out_data; go DONE.
REQ-021 DONE: stall=0; out_valid=1; in_valid ignored (the retiring held instruction); go IDLE.
REQ-022 Latency LAT in cycles from core_start to capture: FADD 3, FSUB 3, FMUL 2, FDIV 10, FSQRT 10, FCVTWS 2, FCVTSW 2, code 4'b1111 1.
REQ-023 A multi-cycle op gives out_valid exactly LAT+1 cycles after its launch cycle.
REQ-024 FSIGNJ {b31,a[30:0]}; FSIGNJN {~b31,a[30:0]}; FSIGNJX {a31^b31,a[30:0]}.
REQ-025 FHALF: exponent 0 -> {a31,31'b0}; otherwise exponent-1, mantissa unchanged.
REQ-026 FEQ/FLT/FLE: sign-magnitude compare, +0 equals -0; result in bit0, bits 31:1 zero.
REQ-027 FLEABS: a[30:0] <= b[30:0].
REQ-028 NaN operands are unsupported; compare results for NaN inputs are unspecified.
REQ-029 flush in BUSY or DONE: go IDLE next cycle; no out_valid; stall=0 in the flush cycle.
REQ-030 flush in IDLE: suppress acceptance that cycle (no core_start, no out_valid).
REQ-031 flush overrides every other transition.
REQ-032 out_valid is low in every cycle not named in REQ-018/REQ-021.

Reset
REQ-033 On rst: state=IDLE, cnt=0, out_valid=0, out_data=0, out_rd=0, out_int_dst=0, core_start=0, core_a=core_b=0, stall=0, busy=0.
REQ-034 rst mid-operation drops the op silently; a later core_result is ignored.

Structure
REQ-035 A shared package holds: the 4-bit op-code constants (FEQ..FSIGNJX 0-7, FADD 8, FSUB 9, FDIV 10, FSQRT 11, FCVTWS 12, FCVTSW 13, FMUL 14); the LAT table function; the state enum.
REQ-036 One sub-module, fpu_simple_unit, holds the purely combinational REQ-024..027 logic.

Verification
REQ-037 FSIGNJN a=0x3F800000, b=0x3F800000 -> out_valid next cycle, out_data=0xBF800000, stall never high.
REQ-038 FDIV a=0x40400000, b=0x3F800000, core returns 0x40400000 -> one core_start pulse; stall high 11 cycles; out_valid 11 cycles after launch, out_data=0x40400000.
REQ-039 FLE a=0x80000000, b=0x00000000 -> out_data=1; FLT on the same operands -> 0; out_int_dst follows the input.
REQ-040 FHALF a=0x40000000 -> 0x3F800000; a=0x80000001 -> 0x80000000.
REQ-041 FMUL, flush asserted in the second BUSY cycle -> no out_valid; stall low in the flush cycle; next FADD launches normally.
REQ-042 rst asserted during FSQRT BUSY -> all outputs zero immediately; after release, FEQ 0x00000000 vs 0x80000000 -> out_data=1.
